// File: rtl/pipelined_multiplier.sv
// Signed x unsigned shift-and-add multiplier: one register stage per multiplier bit, one result per clock.
// Define ADDEND_EN to add a signed addend port that is summed into the product at the output stage.
module pipelined_multiplier #(
  parameter int multiplicand_width = 12,
  parameter int multiplier_width   = 6,
`ifdef ADDEND_EN
  localparam int product_width = multiplicand_width + multiplier_width + 1
`else
  localparam int product_width = multiplicand_width + multiplier_width
`endif
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            input_valid,
  input  logic [multiplicand_width-1:0]   multiplicand,
  input  logic [multiplier_width-1:0]     multiplier,
`ifdef ADDEND_EN
  input  logic [multiplicand_width-1:0]   addend,
`endif
  output logic                            output_valid,
  output logic signed [product_width-1:0] product
);

  localparam int MCW = multiplicand_width;
  localparam int MRW = multiplier_width;
  localparam int AW  = MCW + MRW;
  localparam int PW  = product_width;

  // Index 0 is the input register; index i+1 holds the result of add stage i.
  logic [MCW-1:0] mag_q  [MRW];
  logic [MRW-1:0] mplr_q [MRW];
  logic [AW-1:0]  acc_q  [MRW+1];
  logic           neg_q  [MRW+1];
  logic           vld_q  [MRW+1];
`ifdef ADDEND_EN
  logic [MCW-1:0] add_q  [MRW+1];
`endif

  logic [AW-1:0]  acc_d  [MRW];
  logic [MCW-1:0] mag_d;
  logic [PW-1:0]  acc_ext;
  logic [PW-1:0]  signed_acc;
  logic [PW-1:0]  product_d;

  // Unsigned MCW bits hold |-2^(MCW-1)| exactly, so no extra magnitude bit is needed.
  assign mag_d = multiplicand[MCW-1] ? ('0 - multiplicand) : multiplicand;

  always_comb begin
    for (int i = 0; i < MRW; i++) begin
      acc_d[i] = acc_q[i] + (mplr_q[i][i] ? (AW'(mag_q[i]) << i) : '0);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MRW; i++) begin
        mag_q[i]  <= '0;
        mplr_q[i] <= '0;
      end
      for (int i = 0; i <= MRW; i++) begin
        acc_q[i] <= '0;
        neg_q[i] <= 1'b0;
        vld_q[i] <= 1'b0;
`ifdef ADDEND_EN
        add_q[i] <= '0;
`endif
      end
    end else begin
      mag_q[0]  <= mag_d;
      mplr_q[0] <= multiplier;
      acc_q[0]  <= '0;
      neg_q[0]  <= multiplicand[MCW-1];
      vld_q[0]  <= input_valid;
`ifdef ADDEND_EN
      add_q[0]  <= addend;
`endif
      for (int i = 0; i < MRW; i++) begin
        acc_q[i+1] <= acc_d[i];
        neg_q[i+1] <= neg_q[i];
        vld_q[i+1] <= vld_q[i];
`ifdef ADDEND_EN
        add_q[i+1] <= add_q[i];
`endif
      end
      // The last add stage only needs acc/neg/valid, so magnitude and multiplier stop one short.
      for (int i = 0; i < MRW - 1; i++) begin
        mag_q[i+1]  <= mag_q[i];
        mplr_q[i+1] <= mplr_q[i];
      end
    end
  end

  // Negating a zero accumulator yields zero, so no -0 artefact can appear.
  assign acc_ext    = PW'(acc_q[MRW]);
  assign signed_acc = neg_q[MRW] ? ('0 - acc_ext) : acc_ext;

`ifdef ADDEND_EN
  assign product_d = signed_acc + {{(PW-MCW){add_q[MRW][MCW-1]}}, add_q[MRW]};
`else
  assign product_d = signed_acc;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      output_valid <= 1'b0;
      product      <= '0;
    end else begin
      output_valid <= vld_q[MRW];
      product      <= product_d;
    end
  end

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Self-checking bench for pipelined_multiplier: vector table, scoreboard queue and valid-pattern tracker.
// Covers the ADDEND_EN build as well when that macro is defined.
`timescale 1ns/1ps
module tb_pipelined_multiplier;

  localparam int MCW = 12;
  localparam int MRW = 6;
`ifdef ADDEND_EN
  localparam int PW = MCW + MRW + 1;
`else
  localparam int PW = MCW + MRW;
`endif
  localparam int LAT = MRW + 2;

  typedef struct {
    logic signed [MCW-1:0] a;
    logic [MRW-1:0]        b;
    logic signed [MCW-1:0] c;
    int                    exp;
    string                 tag;
  } vec_t;

  typedef struct {
    int    exp;
    string tag;
  } sb_t;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b1;
  logic                  input_valid = 1'b0;
  logic signed [MCW-1:0] multiplicand = '0;
  logic [MRW-1:0]        multiplier = '0;
`ifdef ADDEND_EN
  logic signed [MCW-1:0] addend = '0;
`endif
  logic                  output_valid;
  logic signed [PW-1:0]  product;

  int   checks = 0;
  int   errors = 0;
  sb_t  expq[$];
  vec_t tbl[$];
  logic [LAT-1:0] vhist = '0;
  sb_t  cur;

  pipelined_multiplier dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .input_valid (input_valid),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
`ifdef ADDEND_EN
    .addend      (addend),
`endif
    .output_valid(output_valid),
    .product     (product)
  );

  always #5 clock = ~clock;

  function automatic int model(input logic signed [MCW-1:0] a, input logic [MRW-1:0] b,
                               input logic signed [MCW-1:0] c);
    int r;
    r = int'(a) * int'(b);
`ifdef ADDEND_EN
    r += int'(c);
`else
    if (c != 0) r = r;
`endif
    return r;
  endfunction

  task automatic drive(input logic v, input logic signed [MCW-1:0] a, input logic [MRW-1:0] b,
                       input logic signed [MCW-1:0] c, input int exp, input string tag);
    sb_t e;
    @(negedge clock);
    input_valid  = v;
    multiplicand = a;
    multiplier   = b;
`ifdef ADDEND_EN
    addend       = c;
`endif
    if (v) begin
      e.exp = exp;
      e.tag = tag;
      expq.push_back(e);
    end
  endtask

  task automatic drive_rand(input logic v, input string tag);
    logic signed [MCW-1:0] a;
    logic [MRW-1:0]        b;
    logic signed [MCW-1:0] c;
    a = MCW'($urandom);
    b = MRW'($urandom);
`ifdef ADDEND_EN
    c = MCW'($urandom);
`else
    c = '0;
`endif
    drive(v, a, b, c, model(a, b, c), tag);
  endtask

  // Reference valid pattern: input_valid delayed by the pipeline latency.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) vhist <= '0;
    else          vhist <= {vhist[LAT-2:0], input_valid};
  end

  always @(negedge clock) begin
    if (reset_n) begin
      checks++;
      if (output_valid !== vhist[LAT-1]) begin
        errors++;
        $display("FAIL valid_pattern output_valid=%0b expected %0b at %0t", output_valid, vhist[LAT-1], $time);
      end
      if (output_valid === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output product=%0d expected no output at %0t", product, $time);
        end else begin
          cur = expq.pop_front();
          if (int'(product) != cur.exp) begin
            errors++;
            $display("FAIL %s product=%0d expected %0d at %0t", cur.tag, product, cur.exp, $time);
          end else begin
            $display("txn %s product=%0d expected %0d ok", cur.tag, product, cur.exp);
          end
        end
      end
    end
  end

  initial begin : main
    int  lat;
    bit  found;
    logic signed [MCW-1:0] q;
    logic [MRW-1:0]        d;
    logic signed [MCW-1:0] r;

    tbl.push_back('{12'sd100,   6'd5,  12'sd0, 500,     "100x5"});
    tbl.push_back('{-12'sd100,  6'd5,  12'sd0, -500,    "-100x5"});
    tbl.push_back('{12'h800,    6'd63, 12'sd0, -129024, "-2048x63"});
    tbl.push_back('{12'sd2047,  6'd63, 12'sd0, 128961,  "2047x63"});
    tbl.push_back('{12'sd0,     6'd63, 12'sd0, 0,       "0x63"});
    tbl.push_back('{-12'sd7,    6'd0,  12'sd0, 0,       "-7x0"});
    tbl.push_back('{-12'sd1,    6'd1,  12'sd0, -1,      "-1x1"});
    tbl.push_back('{12'sd1,     6'd63, 12'sd0, 63,      "1x63"});
`ifdef ADDEND_EN
    tbl.push_back('{12'sd83,    6'd7,  12'sd5,  586,     "83x7+5"});
    tbl.push_back('{12'h800,    6'd63, 12'h800, -131072, "-2048x63-2048"});
`endif

    // Power-on asynchronous reset.
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (output_valid !== 1'b0) begin errors++; $display("FAIL reset_valid output_valid=%0b expected 0", output_valid); end
    checks++;
    if (product !== '0) begin errors++; $display("FAIL reset_product product=%0d expected 0", product); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Reset in the middle of a live stream: outputs clear at once, no stale results later.
    for (int i = 0; i < 12; i++) drive_rand(1'b1, "prereset");
    @(negedge clock);
    #2 reset_n = 1'b0;
    input_valid = 1'b0;
    expq.delete();
    #1;
    checks++;
    if (output_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid output_valid=%0b expected 0", output_valid); end
    checks++;
    if (product !== '0) begin errors++; $display("FAIL midreset_product product=%0d expected 0", product); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (LAT + 2) drive_rand(1'b0, "idle");

    // Single pulse: first post-reset input, check latency and a one-cycle valid.
    drive(1'b1, 12'sd100, 6'd5, 12'sd0, 500, "pulse");
    lat = 0;
    found = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      drive(1'b0, '0, '0, '0, 0, "idle");
      if (output_valid === 1'b1) begin
        found = 1'b1;
        lat = k;
      end
    end
    checks++;
    if (!found || lat != LAT) begin
      errors++;
      $display("FAIL pulse_latency latency=%0d expected %0d (found=%0b)", lat, LAT, found);
    end
    drive(1'b0, '0, '0, '0, 0, "idle");
    checks++;
    if (output_valid !== 1'b0) begin errors++; $display("FAIL pulse_width output_valid=%0b expected 0", output_valid); end

    // Table of directed vectors applied back to back.
    foreach (tbl[i]) drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].exp, tbl[i].tag);
    drive_rand(1'b0, "idle");

    // Random burst, gap, burst.
    for (int i = 0; i < 20; i++) drive_rand(1'b1, "rand_a");
    for (int i = 0; i < 3; i++)  drive_rand(1'b0, "idle");
    for (int i = 0; i < 5; i++)  drive_rand(1'b1, "rand_b");

    // Alternating valid with data changing in every slot.
    for (int i = 0; i < 20; i++) drive_rand(1'(i % 2 == 0), "toggle");

`ifdef ADDEND_EN
    // Rebuild dividend = quotient*divisor + remainder.
    for (int i = 0; i < 100; i++) begin
      d = MRW'($urandom_range(63, 1));
      q = MCW'($urandom_range(1023, 0)) - 12'sd512;
      r = MCW'($urandom_range(int'(d) - 1, 0));
      drive(1'b1, q, d, r, int'(q) * int'(d) + int'(r), "recon");
    end
`endif

    repeat (LAT + 4) drive_rand(1'b0, "idle");
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain outstanding=%0d expected 0", expq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
